// File: rtl/stream_frame_monitor_pkg.sv
// Shared types, error-bit indices and byte-lane helpers for the stream frame monitor.
package stream_frame_monitor_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } chk_state_t;

    localparam int ERR_NO_EOP = 0;
    localparam int ERR_ORPHAN = 1;
    localparam int ERR_STRB   = 2;
    localparam int ERR_LONG   = 3;
    localparam int ERR_SHORT  = 4;
    localparam int ERR_W      = 5;

    // data(64) + strb(8) + sop + eop
    localparam int PAYLOAD_W  = 74;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // True when the set bits form one run starting at bit 0 (an all-zero strobe also passes).
    function automatic logic strb_contig(input logic [7:0] v);
        return ((v & (v + 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer: a registered output stage plus one overflow slot, with a registered ready.
module stream_skid_buf #(
    parameter int WIDTH = 74
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] skid_r;
    logic             head_vld_r;
    logic             skid_vld_r;
    logic             ready_r;

    logic [WIDTH-1:0] head_n_s;
    logic [WIDTH-1:0] skid_n_s;
    logic             head_vld_n_s;
    logic             skid_vld_n_s;
    logic             in_fire_s;
    logic             head_free_s;

    assign in_fire_s   = in_valid & ready_r;
    assign head_free_s = ~head_vld_r | out_ready;

    // Next-entry selection: the output stage refills from the skid slot first to keep order.
    always_comb begin
        head_n_s     = head_r;
        skid_n_s     = skid_r;
        head_vld_n_s = head_vld_r;
        skid_vld_n_s = skid_vld_r;
        if (head_free_s) begin
            if (skid_vld_r) begin
                head_n_s     = skid_r;
                head_vld_n_s = 1'b1;
                if (in_fire_s) begin
                    skid_n_s     = in_data;
                    skid_vld_n_s = 1'b1;
                end else begin
                    skid_vld_n_s = 1'b0;
                end
            end else if (in_fire_s) begin
                head_n_s     = in_data;
                head_vld_n_s = 1'b1;
            end else begin
                head_vld_n_s = 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                skid_n_s     = in_data;
                skid_vld_n_s = 1'b1;
            end else begin
                skid_vld_n_s = skid_vld_r;
            end
        end
    end

    // Entry storage and ready register; ready drops only when both entries will be occupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r     <= {WIDTH{1'b0}};
            skid_r     <= {WIDTH{1'b0}};
            head_vld_r <= 1'b0;
            skid_vld_r <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            head_r     <= head_n_s;
            skid_r     <= skid_n_s;
            head_vld_r <= head_vld_n_s;
            skid_vld_r <= skid_vld_n_s;
            ready_r    <= ~(head_vld_n_s & skid_vld_n_s);
        end
    end

    assign in_ready  = ready_r;
    assign out_data  = head_r;
    assign out_valid = head_vld_r;

endmodule

// File: rtl/stream_frame_monitor.sv
// Passive packet-framing monitor on a 64-bit stream: forwards every beat through a skid buffer
// while tracking packet lengths, totals and sticky framing errors from accepted input beats.
module stream_frame_monitor
    import stream_frame_monitor_pkg::*;
#(
    parameter int MAX_PKT_BYTES = 9600,
    parameter int MIN_PKT_BYTES = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       s_data,
    input  logic [7:0]        s_strb,
    input  logic              s_valid,
    input  logic              s_sop,
    input  logic              s_eop,
    output logic              s_ready,
    output logic [63:0]       m_data,
    output logic [7:0]        m_strb,
    output logic              m_valid,
    output logic              m_sop,
    output logic              m_eop,
    input  logic              m_ready,
    output logic [31:0]       pkt_count,
    output logic [47:0]       byte_count,
    output logic [15:0]       err_count,
    output logic [15:0]       last_len,
    output logic              len_valid,
    output logic [ERR_W-1:0]  err_flags,
    input  logic              clr_err
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_BYTES);
    localparam logic [15:0] MIN_LEN = 16'(MIN_PKT_BYTES);

    logic [PAYLOAD_W-1:0] in_payload_s;
    logic [PAYLOAD_W-1:0] out_payload_s;

    assign in_payload_s = {s_data, s_strb, s_sop, s_eop};

    stream_skid_buf #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_payload_s),
        .in_valid  (s_valid),
        .in_ready  (s_ready),
        .out_data  (out_payload_s),
        .out_valid (m_valid),
        .out_ready (m_ready)
    );

    assign m_data = out_payload_s[73:10];
    assign m_strb = out_payload_s[9:2];
    assign m_sop  = out_payload_s[1];
    assign m_eop  = out_payload_s[0];

    function automatic logic [ERR_W-1:0] len_errs(input logic [15:0] len);
        logic [ERR_W-1:0] e;
        e = {ERR_W{1'b0}};
        if (len > MAX_LEN) begin
            e[ERR_LONG] = 1'b1;
        end else if (len < MIN_LEN) begin
            e[ERR_SHORT] = 1'b1;
        end else begin
            e = {ERR_W{1'b0}};
        end
        return e;
    endfunction

    chk_state_t       state_r;
    logic [15:0]      acc_r;
    logic [31:0]      pkt_count_r;
    logic [47:0]      byte_count_r;
    logic [15:0]      err_count_r;
    logic [15:0]      last_len_r;
    logic             len_valid_r;
    logic [ERR_W-1:0] err_flags_r;

    logic             in_fire_s;
    logic [3:0]       beat_bytes_s;
    logic [15:0]      beat_len_s;
    logic [16:0]      sum_wide_s;
    logic [15:0]      sum_sat_s;
    logic             strb_bad_s;

    assign in_fire_s    = s_valid & s_ready;
    assign beat_bytes_s = popcount8(s_strb);
    assign beat_len_s   = {12'd0, beat_bytes_s};
    assign sum_wide_s   = {1'b0, acc_r} + {13'd0, beat_bytes_s};
    assign sum_sat_s    = sum_wide_s[16] ? 16'hFFFF : sum_wide_s[15:0];
    assign strb_bad_s   = ~strb_contig(s_strb) | (~s_eop & (s_strb != 8'hFF)) | (s_strb == 8'h00);

    // close_a ends the packet in progress; close_b ends a packet that starts and stops on this beat.
    chk_state_t       state_n_s;
    logic [15:0]      acc_n_s;
    logic             close_a_s;
    logic [15:0]      len_a_s;
    logic             close_b_s;
    logic [15:0]      len_b_s;
    logic [3:0]       byte_add_s;
    logic [ERR_W-1:0] frame_err_s;
    logic [ERR_W-1:0] beat_err_s;
    logic [1:0]       done_cnt_s;

    // Framing decisions for the beat being accepted this cycle.
    always_comb begin
        state_n_s   = state_r;
        acc_n_s     = acc_r;
        close_a_s   = 1'b0;
        len_a_s     = acc_r;
        close_b_s   = 1'b0;
        len_b_s     = beat_len_s;
        byte_add_s  = 4'd0;
        frame_err_s = {ERR_W{1'b0}};
        if (in_fire_s) begin
            frame_err_s[ERR_STRB] = strb_bad_s;
            case (state_r)
                IDLE: begin
                    if (s_sop) begin
                        byte_add_s = beat_bytes_s;
                        if (s_eop) begin
                            close_b_s = 1'b1;
                        end else begin
                            state_n_s = IN_PKT;
                            acc_n_s   = beat_len_s;
                        end
                    end else begin
                        frame_err_s[ERR_ORPHAN] = 1'b1;
                    end
                end
                IN_PKT: begin
                    byte_add_s = beat_bytes_s;
                    if (s_sop) begin
                        frame_err_s[ERR_NO_EOP] = 1'b1;
                        close_a_s = 1'b1;
                        len_a_s   = acc_r;
                        if (s_eop) begin
                            close_b_s = 1'b1;
                            state_n_s = IDLE;
                        end else begin
                            acc_n_s = beat_len_s;
                        end
                    end else if (s_eop) begin
                        close_a_s = 1'b1;
                        len_a_s   = sum_sat_s;
                        state_n_s = IDLE;
                    end else begin
                        acc_n_s = sum_sat_s;
                    end
                end
                default: begin
                    state_n_s = IDLE;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    assign beat_err_s = frame_err_s
                      | (close_a_s ? len_errs(len_a_s) : {ERR_W{1'b0}})
                      | (close_b_s ? len_errs(len_b_s) : {ERR_W{1'b0}});
    assign done_cnt_s = {1'b0, close_a_s} + {1'b0, close_b_s};

    // Checker state, running totals and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            acc_r        <= 16'd0;
            pkt_count_r  <= 32'd0;
            byte_count_r <= 48'd0;
            err_count_r  <= 16'd0;
            last_len_r   <= 16'd0;
            len_valid_r  <= 1'b0;
            err_flags_r  <= {ERR_W{1'b0}};
        end else begin
            state_r      <= state_n_s;
            acc_r        <= acc_n_s;
            len_valid_r  <= close_a_s | close_b_s;
            pkt_count_r  <= pkt_count_r + {30'd0, done_cnt_s};
            byte_count_r <= byte_count_r + {44'd0, byte_add_s};
            err_flags_r  <= (clr_err ? {ERR_W{1'b0}} : err_flags_r) | beat_err_s;
            if (close_a_s | close_b_s) begin
                last_len_r <= close_b_s ? len_b_s : len_a_s;
            end
            if ((|beat_err_s) && (err_count_r != 16'hFFFF)) begin
                err_count_r <= err_count_r + 16'd1;
            end
        end
    end

    assign pkt_count  = pkt_count_r;
    assign byte_count = byte_count_r;
    assign err_count  = err_count_r;
    assign last_len   = last_len_r;
    assign len_valid  = len_valid_r;
    assign err_flags  = err_flags_r;

endmodule

// File: tb/tb_stream_frame_monitor.sv
// Self-checking bench: scoreboard on the forwarded stream plus table-driven packet checks.
module tb_stream_frame_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_data;
    logic [7:0]  s_strb;
    logic        s_valid, s_sop, s_eop, s_ready;
    logic [63:0] m_data;
    logic [7:0]  m_strb;
    logic        m_valid, m_sop, m_eop, m_ready;
    logic [31:0] pkt_count;
    logic [47:0] byte_count;
    logic [15:0] err_count, last_len;
    logic        len_valid;
    logic [4:0]  err_flags;
    logic        clr_err;

    always #5 clk = ~clk;

    stream_frame_monitor dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_strb(s_strb), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop), .s_ready(s_ready),
        .m_data(m_data), .m_strb(m_strb), .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_ready(m_ready),
        .pkt_count(pkt_count), .byte_count(byte_count), .err_count(err_count),
        .last_len(last_len), .len_valid(len_valid), .err_flags(err_flags), .clr_err(clr_err)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        sop;
        logic        eop;
        int          cyc;
    } beat_t;

    typedef struct {
        int          nbeats;
        logic [7:0]  last_strb;
        logic [15:0] len;
        logic [4:0]  flags;
    } vec_t;

    beat_t       sb_q[$];
    vec_t        vecs[8];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;
    bit          tog = 1'b0;
    bit          ready_chk = 1'b0;
    bit          saw_full = 1'b0;
    bit          acc_flag = 1'b0;
    int          exp_pkt = 0;
    int          exp_errc = 0;
    logic [47:0] exp_bytes = 48'd0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: bookkeeping at negedge+1 using values that hold through the next posedge.
    task automatic tick();
        beat_t b;
        beat_t e;
        if (tog) m_ready = ~m_ready;
        #1;
        if (ready_chk) begin
            chk("s_ready_occupancy", 80'(s_ready), 80'(sb_q.size() < 2));
            if (!s_ready) saw_full = 1'b1;
        end
        if (m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h expected no beat", m_data);
            end else begin
                e = sb_q.pop_front();
                chk("m_payload", 80'({m_data, m_strb, m_sop, m_eop}), 80'({e.data, e.strb, e.sop, e.eop}));
                if (lat_chk) chk("latency", 80'(cyc - e.cyc), 80'(1));
            end
        end
        acc_flag = s_valid && s_ready;
        if (acc_flag) begin
            b.data = s_data; b.strb = s_strb; b.sop = s_sop; b.eop = s_eop; b.cyc = cyc;
            sb_q.push_back(b);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send_beat(input logic sop, input logic eop, input logic [7:0] strb);
        s_data  = {$urandom, $urandom};
        s_strb  = strb;
        s_sop   = sop;
        s_eop   = eop;
        s_valid = 1'b1;
        acc_flag = 1'b0;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (acc_flag) break;
        end
        if (!acc_flag) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 64 cycles");
        end
        s_valid = 1'b0;
    endtask

    task automatic send_pkt(input int nbeats, input logic [7:0] last_strb);
        for (int i = 0; i < nbeats; i++) begin
            send_beat(i == 0, i == nbeats - 1, (i == nbeats - 1) ? last_strb : 8'hFF);
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int n = 0; n < 50 && sb_q.size() != 0; n++) tick();
        chk("scoreboard_drained", 80'(sb_q.size()), 80'(0));
    endtask

    task automatic chk_totals(input string tag);
        chk({tag, "_pkt_count"}, 80'(pkt_count), 80'(exp_pkt));
        chk({tag, "_byte_count"}, 80'(byte_count), 80'(exp_bytes));
        chk({tag, "_err_count"}, 80'(err_count), 80'(exp_errc));
    endtask

    initial begin
        vecs[0] = '{32'd8,    8'h0F, 16'd60,   5'b00000};
        vecs[1] = '{32'd1,    8'hFF, 16'd8,    5'b10000};
        vecs[2] = '{32'd2,    8'h3F, 16'd14,   5'b00000};
        vecs[3] = '{32'd2,    8'h1F, 16'd13,   5'b10000};
        vecs[4] = '{32'd1200, 8'hFF, 16'd9600, 5'b00000};
        vecs[5] = '{32'd1201, 8'hFF, 16'd9608, 5'b01000};
        vecs[6] = '{32'd1,    8'h0F, 16'd4,    5'b10000};
        vecs[7] = '{32'd3,    8'h01, 16'd17,   5'b00000};

        rst = 1'b1; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        s_data = 64'd0; s_strb = 8'd0; m_ready = 1'b1; clr_err = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_ready", 80'(s_ready), 80'(0));
        chk("rst_m_valid", 80'(m_valid), 80'(0));
        chk("rst_m_data", 80'({m_data, m_strb, m_sop, m_eop}), 80'(0));
        chk("rst_len", 80'({last_len, len_valid}), 80'(0));
        chk("rst_err_flags", 80'(err_flags), 80'(0));
        chk_totals("rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_rst", 80'(s_ready), 80'(1));

        // Table of whole packets with m_ready held high.
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            clear_flags();
            send_pkt(vecs[i].nbeats, vecs[i].last_strb);
            exp_pkt++;
            exp_bytes += 48'(vecs[i].len);
            if (vecs[i].flags != 5'd0) exp_errc++;
            chk($sformatf("vec%0d_len_valid", i), 80'(len_valid), 80'(1));
            chk($sformatf("vec%0d_last_len", i), 80'(last_len), 80'(vecs[i].len));
            chk($sformatf("vec%0d_err_flags", i), 80'(err_flags), 80'(vecs[i].flags));
            chk_totals($sformatf("vec%0d", i));
            idle(1);
            chk($sformatf("vec%0d_len_valid_drop", i), 80'(len_valid), 80'(0));
        end
        lat_chk = 1'b0;
        drain();

        // 60-byte packet under alternating downstream backpressure.
        clear_flags();
        tog = 1'b1; ready_chk = 1'b1; saw_full = 1'b0;
        send_pkt(8, 8'h0F);
        exp_pkt++; exp_bytes += 48'd60;
        for (int n = 0; n < 50 && sb_q.size() != 0; n++) tick();
        tog = 1'b0; ready_chk = 1'b0; m_ready = 1'b1;
        chk("bp_skid_filled", 80'(saw_full), 80'(1));
        chk("bp_last_len", 80'(last_len), 80'(60));
        chk("bp_err_flags", 80'(err_flags), 80'(0));
        chk_totals("bp");
        drain();

        // Missing eop: new sop closes the 24-byte packet, then a short 12-byte packet.
        clear_flags();
        send_beat(1'b1, 1'b0, 8'hFF);
        send_beat(1'b0, 1'b0, 8'hFF);
        send_beat(1'b0, 1'b0, 8'hFF);
        send_beat(1'b1, 1'b0, 8'hFF);
        exp_pkt++; exp_bytes += 48'd32; exp_errc++;
        chk("noeop_flags", 80'(err_flags), 80'(5'b00001));
        chk("noeop_last_len", 80'(last_len), 80'(24));
        chk("noeop_len_valid", 80'(len_valid), 80'(1));
        chk_totals("noeop");
        send_beat(1'b0, 1'b1, 8'h0F);
        exp_pkt++; exp_bytes += 48'd4; exp_errc++;
        chk("noeop_short_flags", 80'(err_flags), 80'(5'b10001));
        chk("noeop_short_len", 80'(last_len), 80'(12));
        chk_totals("noeop_short");
        drain();

        // Orphan beat in IDLE: forwarded, flagged, not counted.
        clear_flags();
        send_beat(1'b0, 1'b0, 8'hFF);
        exp_errc++;
        chk("orphan_flags", 80'(err_flags), 80'(5'b00010));
        chk_totals("orphan");
        drain();

        // Partial strobe on a middle beat.
        clear_flags();
        send_beat(1'b1, 1'b0, 8'hFF);
        send_beat(1'b0, 1'b0, 8'h0F);
        send_beat(1'b0, 1'b1, 8'hFF);
        exp_pkt++; exp_bytes += 48'd20; exp_errc++;
        chk("strb_flags", 80'(err_flags), 80'(5'b00100));
        chk("strb_last_len", 80'(last_len), 80'(20));
        chk_totals("strb");
        drain();

        // clr_err in the same cycle as a new error: old flags go, new flag stays.
        clr_err = 1'b1;
        send_beat(1'b0, 1'b1, 8'hFF);
        clr_err = 1'b0;
        exp_errc++;
        chk("clr_vs_err_flags", 80'(err_flags), 80'(5'b00010));
        clear_flags();
        chk("clr_flags", 80'(err_flags), 80'(0));
        chk_totals("clr");
        drain();

        // Reset in the middle of a packet.
        send_beat(1'b1, 1'b0, 8'hFF);
        send_beat(1'b0, 1'b0, 8'hFF);
        #2 rst = 1'b1;
        #1;
        chk("midrst_m_valid", 80'(m_valid), 80'(0));
        chk("midrst_s_ready", 80'(s_ready), 80'(0));
        chk("midrst_m_data", 80'({m_data, m_strb, m_sop, m_eop}), 80'(0));
        chk("midrst_len", 80'({last_len, len_valid}), 80'(0));
        chk("midrst_err_flags", 80'(err_flags), 80'(0));
        sb_q.delete();
        exp_pkt = 0; exp_bytes = 48'd0; exp_errc = 0;
        chk_totals("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_pkt(8, 8'hFF);
        exp_pkt++; exp_bytes += 48'd64;
        chk("postrst_last_len", 80'(last_len), 80'(64));
        chk("postrst_err_flags", 80'(err_flags), 80'(0));
        chk_totals("postrst");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
